lcd_cmd_scheduler: RTL and testbench

- Front-end sequencer for the 8x8 image-display engine (shift/max/min/avg/rotate/mirror/write command set).
- Arbitrates two host command ports round-robin into a small FIFO.
- Issues FIFO commands to the engine one at a time, following the engine's cmd_valid/busy handshake.
- Closes the command stream once the terminal WRITE (0x0) command is queued, then reports completion when the engine signals done.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_cmd_fifo.sv | 56 +++++
 rtl/lcd_cmd_scheduler.sv | 157 +++++++++++++++
 tb/tb_lcd_cmd_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler: command codes, legality limit
// and scheduler state encodings.
package lcd_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE       = 4'h0,
    CMD_SHIFT_UP    = 4'h1,
    CMD_SHIFT_DOWN  = 4'h2,
    CMD_SHIFT_LEFT  = 4'h3,
    CMD_SHIFT_RIGHT = 4'h4,
    CMD_MAX         = 4'h5,
    CMD_MIN         = 4'h6,
    CMD_AVG         = 4'h7,
    CMD_ROT_CCW     = 4'h8,
    CMD_ROT_CW      = 4'h9,
    CMD_MIRROR_X    = 4'hA,
    CMD_MIRROR_Y    = 4'hB
  } lcd_cmd_e;

  localparam logic [3:0] CMD_MAX_LEGAL = 4'hB;

  // Scheduler states kept as plain encoded constants for older tooling.
  typedef logic [2:0] sched_state_t;
  localparam sched_state_t ST_BOOT      = 3'd0;
  localparam sched_state_t ST_IDLE      = 3'd1;
  localparam sched_state_t ST_ISSUE     = 3'd2;
  localparam sched_state_t ST_WAIT_ACK  = 3'd3;
  localparam sched_state_t ST_WAIT_IDLE = 3'd4;
  localparam sched_state_t ST_WAIT_DONE = 3'd5;
  localparam sched_state_t ST_FIN       = 3'd6;

  function automatic logic is_legal(input logic [3:0] code);
    return code <= CMD_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO; simultaneous push and pop leave the level unchanged.
// DEPTH must be a power of two so the pointers wrap naturally.
module lcd_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_din,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_dout,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Front-end sequencer for the 8x8 image-display engine: round-robin host arbitration,
// command FIFO and engine issue FSM. Optional perf counter under LCD_SCHED_PERF_EN.
module lcd_cmd_scheduler
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             h0_cmd,
  input  logic                   h0_valid,
  output logic                   h0_ready,
  input  logic [3:0]             h1_cmd,
  input  logic                   h1_valid,
  output logic                   h1_ready,
  output logic [3:0]             eng_cmd,
  output logic                   eng_cmd_valid,
  input  logic                   eng_busy,
  input  logic                   eng_done,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   sched_done,
  output logic [CNT_W-1:0]       drop_cnt
`ifdef LCD_SCHED_PERF_EN
  ,
  output logic [15:0]            perf_cycles
`endif
);

  sched_state_t     r_state;
  logic             r_rr;
  logic             r_sealed;
  logic             r_sched_done;
  logic [3:0]       r_eng_cmd;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_open;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_xfer0;
  logic             w_xfer;
  logic [3:0]       w_in_cmd;
  logic             w_legal;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic [3:0]       w_head;
  logic             w_full;
  logic             w_empty;
  logic [$clog2(DEPTH):0] w_level;

  // Any port may only transfer while the queue has room and the stream is still open.
  assign w_open   = !w_full && !r_sealed && (r_state != ST_FIN);
  assign w_grant0 = h0_valid && (!h1_valid || !r_rr);
  assign w_grant1 = h1_valid && (!h0_valid || r_rr);
  assign h0_ready = w_grant0 && w_open;
  assign h1_ready = w_grant1 && w_open;

  assign w_xfer0  = h0_ready;
  assign w_xfer   = h0_ready || h1_ready;
  assign w_in_cmd = w_xfer0 ? h0_cmd : h1_cmd;
  assign w_legal  = is_legal(w_in_cmd);
  assign w_push   = w_xfer && w_legal;
  assign w_drop   = w_xfer && !w_legal;
  assign w_pop    = (r_state == ST_IDLE) && !w_empty && !eng_busy;

  lcd_cmd_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (4)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_in_cmd),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Illegal codes still count as a transfer for fairness, but are only tallied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr       <= 1'b0;
      r_sealed   <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_xfer) r_rr <= w_xfer0;
      if (w_push && (w_in_cmd == CMD_WRITE)) r_sealed <= 1'b1;
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_BOOT;
      r_eng_cmd    <= 4'h0;
      r_sched_done <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (!eng_busy) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_pop) begin
            r_eng_cmd <= w_head;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (eng_busy) r_state <= (r_eng_cmd == CMD_WRITE) ? ST_WAIT_DONE : ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (!eng_busy) r_state <= ST_IDLE;
        end
        ST_WAIT_DONE: begin
          if (eng_done) begin
            r_sched_done <= 1'b1;
            r_state      <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_state <= ST_FIN;
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign eng_cmd       = r_eng_cmd;
  assign eng_cmd_valid = (r_state == ST_ISSUE);
  assign fifo_level    = w_level;
  assign sched_done    = r_sched_done;
  assign drop_cnt      = r_drop_cnt;

`ifdef LCD_SCHED_PERF_EN
  logic [15:0] r_perf_cycles;

  // Counts every post-boot cycle and freezes once the scheduler reaches FIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_cycles <= 16'h0000;
    end else if ((r_state != ST_BOOT) && (r_state != ST_FIN) && (r_perf_cycles != 16'hFFFF)) begin
      r_perf_cycles <= r_perf_cycles + 16'h0001;
    end
  end

  assign perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed self-checking bench for lcd_cmd_scheduler with a simple engine busy model.
// Builds with or without LCD_SCHED_PERF_EN.
module tb_lcd_cmd_scheduler;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] h0Cmd, h1Cmd;
  logic       h0Valid, h1Valid;
  logic       h0Ready, h1Ready;
  logic [3:0] engCmd;
  logic       engCmdValid;
  logic       engBusy;
  logic       engDone;
  logic [2:0] fifoLevel;
  logic       schedDone;
  logic [7:0] dropCnt;
`ifdef LCD_SCHED_PERF_EN
  logic [15:0] perfCycles;
`endif

  logic manualBusy;
  logic engAuto;
  logic autoBusy = 1'b0;
  logic lastStrobe = 1'b0;

  int         cycleCnt = 0;
  logic [3:0] issuedCmd [$];
  int         issuedAt [$];
  int         strobeWhileBusy = 0;
  int         checkCnt = 0;
  int         passCnt = 0;

  lcd_cmd_scheduler #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .h0_cmd        (h0Cmd),
    .h0_valid      (h0Valid),
    .h0_ready      (h0Ready),
    .h1_cmd        (h1Cmd),
    .h1_valid      (h1Valid),
    .h1_ready      (h1Ready),
    .eng_cmd       (engCmd),
    .eng_cmd_valid (engCmdValid),
    .eng_busy      (engBusy),
    .eng_done      (engDone),
    .fifo_level    (fifoLevel),
    .sched_done    (schedDone),
    .drop_cnt      (dropCnt)
`ifdef LCD_SCHED_PERF_EN
    ,
    .perf_cycles   (perfCycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Engine model: busy for exactly the cycle after each issue strobe.
  assign engBusy = engAuto ? autoBusy : manualBusy;

  always @(posedge clk) begin
    #1;
    autoBusy = lastStrobe;
  end

  always @(negedge clk) begin
    lastStrobe = engCmdValid;
    if (engCmdValid) begin
      issuedCmd.push_back(engCmd);
      issuedAt.push_back(cycleCnt);
      if (engBusy) strobeWhileBusy++;
    end
  end

  function automatic logic [3:0] getCmd(input int idx);
    if (idx < issuedCmd.size()) return issuedCmd[idx];
    return 4'hx;
  endfunction

  function automatic int getAt(input int idx);
    if (idx < issuedAt.size()) return issuedAt[idx];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset(input logic busyVal);
    reset      = 1'b1;
    h0Valid    = 1'b0;
    h1Valid    = 1'b0;
    h0Cmd      = 4'h0;
    h1Cmd      = 4'h0;
    engDone    = 1'b0;
    manualBusy = busyVal;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    h0Valid    = 1'b0;
    h1Valid    = 1'b0;
    h0Cmd      = 4'h0;
    h1Cmd      = 4'h0;
    engDone    = 1'b0;
    engAuto    = 1'b0;
    manualBusy = 1'b1;
    @(negedge clk);
    checkCnt++;
    if (fifoLevel !== 3'd0) $display("[TB] FAIL reset_level: got %0d expected 0", fifoLevel);
    else passCnt++;
    checkCnt++;
    if (engCmdValid !== 1'b0 || engCmd !== 4'h0) $display("[TB] FAIL reset_eng: got valid=%b cmd=%0h expected 0/0", engCmdValid, engCmd);
    else passCnt++;
    checkCnt++;
    if (schedDone !== 1'b0 || dropCnt !== 8'd0) $display("[TB] FAIL reset_done_drop: got %b/%0d expected 0/0", schedDone, dropCnt);
    else passCnt++;
    checkCnt++;
    if (h0Ready !== 1'b0 || h1Ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b%b expected 00", h0Ready, h1Ready);
    else passCnt++;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_boot_hold;
    int startIdx;
    int fallCycle;
    h0Valid = 1'b1;
    h0Cmd   = 4'h1;
    @(negedge clk);
    checkCnt++;
    if (h0Ready !== 1'b1) $display("[TB] FAIL boot_accept: got %b expected 1", h0Ready);
    else passCnt++;
    tick(1);
    h0Valid  = 1'b0;
    startIdx = issuedCmd.size();
    tick(62);
    @(negedge clk);
    checkCnt++;
    if (issuedCmd.size() != startIdx || fifoLevel !== 3'd1) $display("[TB] FAIL boot_hold: got issues=%0d level=%0d expected 0/1", issuedCmd.size() - startIdx, fifoLevel);
    else passCnt++;
    tick(1);
    manualBusy = 1'b0;
    fallCycle  = cycleCnt;
    tick(5);
    @(negedge clk);
    checkCnt++;
    if (issuedCmd.size() != startIdx + 1) $display("[TB] FAIL boot_issue_count: got %0d expected 1", issuedCmd.size() - startIdx);
    else passCnt++;
    checkCnt++;
    if (getCmd(startIdx) !== 4'h1 || getAt(startIdx) != fallCycle + 2) $display("[TB] FAIL boot_issue: got cmd=%0h at +%0d expected 1 at +2", getCmd(startIdx), getAt(startIdx) - fallCycle);
    else passCnt++;
    tick(1);
    manualBusy = 1'b1;
    tick(1);
    manualBusy = 1'b0;
    tick(3);
    @(negedge clk);
    checkCnt++;
    if (engCmd !== 4'h1 || engCmdValid !== 1'b0) $display("[TB] FAIL boot_hold_cmd: got cmd=%0h valid=%b expected 1/0", engCmd, engCmdValid);
    else passCnt++;
  endtask

  task automatic test_round_robin;
    int startIdx;
    logic [3:0] expOrder [4];
    expOrder = '{4'h3, 4'h4, 4'h3, 4'h4};
    doReset(1'b1);
    h0Valid = 1'b1;
    h0Cmd   = 4'h3;
    h1Valid = 1'b1;
    h1Cmd   = 4'h4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkCnt++;
      if (h0Ready !== (k % 2 == 0) || h1Ready !== (k % 2 == 1)) $display("[TB] FAIL rr_grant%0d: got %b%b expected %b%b", k, h0Ready, h1Ready, (k % 2 == 0), (k % 2 == 1));
      else passCnt++;
      tick(1);
    end
    @(negedge clk);
    checkCnt++;
    if (fifoLevel !== 3'd4 || h0Ready !== 1'b0 || h1Ready !== 1'b0) $display("[TB] FAIL rr_full: got level=%0d ready=%b%b expected 4/00", fifoLevel, h0Ready, h1Ready);
    else passCnt++;
    tick(1);
    h0Valid  = 1'b0;
    h1Valid  = 1'b0;
    startIdx = issuedCmd.size();
    engAuto  = 1'b1;
    tick(25);
    for (int i = 0; i < 4; i++) begin
      checkCnt++;
      if (getCmd(startIdx + i) !== expOrder[i]) $display("[TB] FAIL rr_order%0d: got %0h expected %0h", i, getCmd(startIdx + i), expOrder[i]);
      else passCnt++;
    end
  endtask

  task automatic test_handshake;
    int startIdx;
    int pushCycle;
    startIdx  = issuedCmd.size();
    pushCycle = cycleCnt;
    h0Valid = 1'b1;
    h0Cmd   = 4'h6;
    tick(1);
    h0Valid = 1'b0;
    h1Valid = 1'b1;
    h1Cmd   = 4'h8;
    tick(1);
    h1Valid = 1'b0;
    tick(15);
    checkCnt++;
    if (issuedCmd.size() != startIdx + 2 || getCmd(startIdx) !== 4'h6 || getCmd(startIdx + 1) !== 4'h8) $display("[TB] FAIL hs_cmds: got n=%0d %0h %0h expected 2 6 8", issuedCmd.size() - startIdx, getCmd(startIdx), getCmd(startIdx + 1));
    else passCnt++;
    checkCnt++;
    if (getAt(startIdx) != pushCycle + 2) $display("[TB] FAIL hs_latency: got %0d expected 2", getAt(startIdx) - pushCycle);
    else passCnt++;
    checkCnt++;
    if (getAt(startIdx + 1) - getAt(startIdx) != 4) $display("[TB] FAIL hs_spacing: got %0d expected 4", getAt(startIdx + 1) - getAt(startIdx));
    else passCnt++;
    checkCnt++;
    if (strobeWhileBusy != 0) $display("[TB] FAIL hs_strobe_busy: got %0d expected 0", strobeWhileBusy);
    else passCnt++;
  endtask

  task automatic test_illegal_drop;
    int startIdx;
    startIdx = issuedCmd.size();
    h1Valid  = 1'b1;
    h1Cmd    = 4'hD;
    @(negedge clk);
    checkCnt++;
    if (h1Ready !== 1'b1) $display("[TB] FAIL drop_ready: got %b expected 1", h1Ready);
    else passCnt++;
    tick(1);
    h1Cmd = 4'h5;
    @(negedge clk);
    checkCnt++;
    if (dropCnt !== 8'd1 || fifoLevel !== 3'd0) $display("[TB] FAIL drop_count: got drop=%0d level=%0d expected 1/0", dropCnt, fifoLevel);
    else passCnt++;
    tick(1);
    h1Valid = 1'b0;
    @(negedge clk);
    checkCnt++;
    if (fifoLevel !== 3'd1) $display("[TB] FAIL drop_level: got %0d expected 1", fifoLevel);
    else passCnt++;
    tick(10);
    checkCnt++;
    if (issuedCmd.size() != startIdx + 1 || getCmd(startIdx) !== 4'h5) $display("[TB] FAIL drop_issue: got n=%0d cmd=%0h expected 1/5", issuedCmd.size() - startIdx, getCmd(startIdx));
    else passCnt++;
  endtask

  task automatic test_drop_saturate;
    h0Valid = 1'b1;
    h0Cmd   = 4'hF;
    tick(260);
    h0Valid = 1'b0;
    @(negedge clk);
    checkCnt++;
    if (dropCnt !== 8'hFF || fifoLevel !== 3'd0) $display("[TB] FAIL drop_saturate: got drop=%0d level=%0d expected 255/0", dropCnt, fifoLevel);
    else passCnt++;
    tick(1);
  endtask

  task automatic test_seal_done;
    int startIdx;
    int r;
    startIdx = issuedCmd.size();
    r        = cycleCnt;
    h0Valid  = 1'b1;
    h0Cmd    = 4'h7;
    tick(1);
    h0Cmd = 4'h0;
    @(negedge clk);
    checkCnt++;
    if (h0Ready !== 1'b1) $display("[TB] FAIL seal_accept_write: got %b expected 1", h0Ready);
    else passCnt++;
    tick(1);
    h0Cmd   = 4'h2;
    h1Valid = 1'b1;
    h1Cmd   = 4'h2;
    @(negedge clk);
    checkCnt++;
    if (h0Ready !== 1'b0 || h1Ready !== 1'b0) $display("[TB] FAIL seal_ready: got %b%b expected 00", h0Ready, h1Ready);
    else passCnt++;
    tick(3);
    @(negedge clk);
    checkCnt++;
    if (h0Ready !== 1'b0 || h1Ready !== 1'b0) $display("[TB] FAIL seal_ready_hold: got %b%b expected 00", h0Ready, h1Ready);
    else passCnt++;
    tick(6);
    h0Valid = 1'b0;
    h1Valid = 1'b0;
    @(negedge clk);
    checkCnt++;
    if (schedDone !== 1'b0) $display("[TB] FAIL done_early: got %b expected 0", schedDone);
    else passCnt++;
    tick(1);
    engDone = 1'b1;
    @(negedge clk);
    checkCnt++;
    if (schedDone !== 1'b0) $display("[TB] FAIL done_same_cycle: got %b expected 0", schedDone);
    else passCnt++;
    tick(1);
    engDone = 1'b0;
    @(negedge clk);
    checkCnt++;
    if (schedDone !== 1'b1) $display("[TB] FAIL done_set: got %b expected 1", schedDone);
    else passCnt++;
    tick(5);
    @(negedge clk);
    checkCnt++;
    if (schedDone !== 1'b1 || fifoLevel !== 3'd0) $display("[TB] FAIL done_sticky: got done=%b level=%0d expected 1/0", schedDone, fifoLevel);
    else passCnt++;
    checkCnt++;
    if (issuedCmd.size() != startIdx + 2 || getCmd(startIdx) !== 4'h7 || getCmd(startIdx + 1) !== 4'h0) $display("[TB] FAIL seal_issue: got n=%0d %0h %0h expected 2 7 0", issuedCmd.size() - startIdx, getCmd(startIdx), getCmd(startIdx + 1));
    else passCnt++;
    checkCnt++;
    if (getAt(startIdx) != r + 2 || getAt(startIdx + 1) != r + 6) $display("[TB] FAIL seal_timing: got +%0d +%0d expected +2 +6", getAt(startIdx) - r, getAt(startIdx + 1) - r);
    else passCnt++;
  endtask

  task automatic test_reset_midrun;
    engAuto = 1'b0;
    doReset(1'b0);
    for (int k = 0; k < 4; k++) begin
      h0Valid = (k % 2 == 0);
      h1Valid = (k % 2 == 1);
      h0Cmd   = 4'(k + 1);
      h1Cmd   = 4'(k + 1);
      tick(1);
    end
    h0Valid    = 1'b0;
    h1Valid    = 1'b0;
    manualBusy = 1'b1;
    tick(3);
    @(negedge clk);
    checkCnt++;
    if (fifoLevel !== 3'd3 || dut.r_state !== ST_WAIT_IDLE) $display("[TB] FAIL midrun_setup: got level=%0d state=%0d expected 3/%0d", fifoLevel, dut.r_state, ST_WAIT_IDLE);
    else passCnt++;
    #1;
    reset = 1'b1;
    #1;
    checkCnt++;
    if (fifoLevel !== 3'd0 || engCmdValid !== 1'b0 || schedDone !== 1'b0) $display("[TB] FAIL midrun_reset: got level=%0d valid=%b done=%b expected 0/0/0", fifoLevel, engCmdValid, schedDone);
    else passCnt++;
    checkCnt++;
    if (dut.r_state !== ST_BOOT) $display("[TB] FAIL midrun_state: got %0d expected %0d", dut.r_state, ST_BOOT);
    else passCnt++;
    tick(2);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_boot_hold();
    test_round_robin();
    test_handshake();
    test_illegal_drop();
    test_drop_saturate();
    test_seal_done();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d of %0d passed", passCnt, checkCnt);
    $fatal(1, "[TB] watchdog");
  end

endmodule
